// File: rtl/cpu_reg_dumper.sv
// Debug read-out engine: walks x1..x31 through a register-file read port and
// emits a framed little-endian byte stream (header, data bytes, checksum).
module cpu_reg_dumper #(
  parameter int          XLEN   = 32,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [4:0]      rf_addr,
  input  logic [XLEN-1:0] rf_data,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int NB = XLEN / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

  typedef enum logic [2:0] {IDLE, HDR, LOAD, SEND, CSUM, FIN} state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [4:0]        rf_addr_q, rf_addr_d;
  logic [4:0]        index_q, index_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [XLEN-1:0]   shift_q, shift_d;
  logic              hs;

  assign hs = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      rf_addr_q   <= 5'd0;
      index_q     <= 5'd0;
      cnt_q       <= '0;
      csum_q      <= 8'd0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rf_addr_q   <= rf_addr_d;
      index_q     <= index_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      shift_q     <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HDR;
      HDR:     if (hs) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (hs && cnt_q == LAST_BYTE) state_d = (index_q == 5'd31) ? CSUM : LOAD;
      CSUM:    if (hs) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register snapshot is taken once in LOAD; later bytes come from the shifted copy.
  always_comb begin
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rf_addr_d   = rf_addr_q;
    index_d     = index_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    shift_d     = shift_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          out_data_d  = HEADER;
          out_valid_d = 1'b1;
          csum_d      = 8'd0;
          index_d     = 5'd1;
        end
      end
      HDR: begin
        if (hs) begin
          out_valid_d = 1'b0;
          rf_addr_d   = index_q;
        end
      end
      LOAD: begin
        shift_d     = rf_data;
        out_data_d  = rf_data[7:0];
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end
      SEND: begin
        if (hs) begin
          csum_d = csum_q + out_data_q;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q != LAST_BYTE) begin
            shift_d    = shift_q >> 8;
            out_data_d = shift_d[7:0];
          end else if (index_q != 5'd31) begin
            index_d     = index_q + 5'd1;
            rf_addr_d   = index_q + 5'd1;
            out_valid_d = 1'b0;
          end else begin
            out_data_d = csum_d;
          end
        end
      end
      CSUM: begin
        if (hs) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign rf_addr   = rf_addr_q;

endmodule
